// File: rtl/sd_access_arbiter.sv
// Shares one SD host between a raw reader (0) and an eLUKS engine (1), resetting the host on owner change.
// Grant latency is 1 + RST_CYCLES + init-wait cycles on a switch, 2 cycles otherwise; no preemption except by the busy watchdog.
module sd_access_arbiter #(
    parameter int unsigned RST_CYCLES      = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 2**24,
    parameter bit          RESET_ON_SWITCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    output logic [1:0]  gnt_o,
    input  logic [1:0]  r_block_i,
    input  logic [1:0]  r_multi_block_i,
    input  logic [1:0]  r_byte_i,
    input  logic [31:0] block_addr0_i,
    input  logic [31:0] block_addr1_i,
    output logic        spi_r_block,
    output logic        spi_r_multi_block,
    output logic        spi_r_byte,
    output logic [31:0] spi_block_addr,
    output logic        spi_rst,
    input  logic        spi_busy,
    input  logic        spi_err,
    output logic [1:0]  busy_o,
    output logic [1:0]  err_o,
    output logic        timeout_o
);

    typedef enum logic [2:0] {
        IDLE,
        RST_HOST,
        WAIT_READY,
        GRANTED,
        RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [31:0] rst_cnt_q, rst_cnt_d;
    logic [31:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;
    logic        force_rst_q, force_rst_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        spi_rst_q, spi_rst_d;
    logic        pick;
    logic        cmd_en;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rst_cnt_d    = rst_cnt_q;
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
        force_rst_d  = force_rst_q;
        gnt_d        = gnt_q;
        spi_rst_d    = spi_rst_q;
        pick         = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    // On a tie the requester that did not own the host last time wins.
                    pick    = (&req_i) ? ~last_owner_q : req_i[1];
                    owner_d = pick;
                    if (force_rst_q || (RESET_ON_SWITCH && (pick != last_owner_q))) begin
                        state_d     = RST_HOST;
                        spi_rst_d   = 1'b1;
                        rst_cnt_d   = 32'd0;
                        force_rst_d = 1'b0;
                    end else begin
                        state_d   = WAIT_READY;
                        spi_rst_d = 1'b0;
                    end
                end
            end
            RST_HOST: begin
                if (rst_cnt_q == RST_CYCLES - 32'd1) begin
                    state_d   = WAIT_READY;
                    spi_rst_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 32'd1;
                end
            end
            WAIT_READY: begin
                if (!spi_busy) begin
                    state_d = GRANTED;
                    gnt_d   = owner_q ? 2'b10 : 2'b01;
                    wdog_d  = 32'd0;
                end
            end
            GRANTED: begin
                if (spi_busy) begin
                    wdog_d = wdog_q + 32'd1;
                    // A host stuck busy is forcibly taken back and re-initialised before reuse.
                    if (wdog_q + 32'd1 == TIMEOUT_CYCLES) begin
                        timeout_d   = 1'b1;
                        force_rst_d = 1'b1;
                        state_d     = RELEASE;
                        gnt_d       = 2'b00;
                    end
                end else begin
                    wdog_d = 32'd0;
                    if (!req_i[owner_q]) begin
                        state_d = RELEASE;
                        gnt_d   = 2'b00;
                    end
                end
            end
            RELEASE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            rst_cnt_q    <= 32'd0;
            wdog_q       <= 32'd0;
            timeout_q    <= 1'b0;
            force_rst_q  <= 1'b1;
            gnt_q        <= 2'b00;
            spi_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rst_cnt_q    <= rst_cnt_d;
            wdog_q       <= wdog_d;
            timeout_q    <= timeout_d;
            force_rst_q  <= force_rst_d;
            gnt_q        <= gnt_d;
            spi_rst_q    <= spi_rst_d;
        end
    end

    // Commands only flow while the owner still asserts its request.
    assign cmd_en            = (state_q == GRANTED) && req_i[owner_q];
    assign spi_r_block       = cmd_en & r_block_i[owner_q];
    assign spi_r_multi_block = cmd_en & r_multi_block_i[owner_q];
    assign spi_r_byte        = cmd_en & r_byte_i[owner_q];
    assign spi_block_addr    = cmd_en ? (owner_q ? block_addr1_i : block_addr0_i) : 32'd0;

    assign gnt_o     = gnt_q;
    assign spi_rst   = spi_rst_q;
    assign timeout_o = timeout_q;
    assign busy_o[0] = gnt_q[0] ? spi_busy : 1'b1;
    assign busy_o[1] = gnt_q[1] ? spi_busy : 1'b1;
    assign err_o[0]  = gnt_q[0] & spi_err;
    assign err_o[1]  = gnt_q[1] & spi_err;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Randomized sessions against a session-level arbitration model; a negedge monitor scores grants and routing.
module tb_sd_access_arbiter;

    localparam int RSTC      = 16;
    localparam int TMO       = 100;
    localparam int INIT_BUSY = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i;
    logic [1:0]  gnt_o;
    logic [1:0]  r_block_i, r_multi_block_i, r_byte_i;
    logic [31:0] block_addr0_i, block_addr1_i;
    logic        spi_r_block, spi_r_multi_block, spi_r_byte;
    logic [31:0] spi_block_addr;
    logic        spi_rst;
    logic        spi_busy, spi_err;
    logic [1:0]  busy_o, err_o;
    logic        timeout_o;

    sd_access_arbiter #(
        .RST_CYCLES(RSTC),
        .TIMEOUT_CYCLES(TMO),
        .RESET_ON_SWITCH(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o),
        .r_block_i(r_block_i), .r_multi_block_i(r_multi_block_i), .r_byte_i(r_byte_i),
        .block_addr0_i(block_addr0_i), .block_addr1_i(block_addr1_i),
        .spi_r_block(spi_r_block), .spi_r_multi_block(spi_r_multi_block),
        .spi_r_byte(spi_r_byte), .spi_block_addr(spi_block_addr),
        .spi_rst(spi_rst), .spi_busy(spi_busy), .spi_err(spi_err),
        .busy_o(busy_o), .err_o(err_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic own;
        int   at_cyc;
    } grant_t;

    grant_t     exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         init_cnt = 0;
    logic       xfer_busy;
    logic [1:0] exp_gnt;
    logic       exp_tmo;
    logic       last_m, force_m;
    bit         mon_en = 1'b0;
    logic [1:0] prev_gnt = 2'b00;

    // SD host model: stays busy while held in reset and for INIT_BUSY cycles after release.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (spi_rst) init_cnt <= INIT_BUSY;
        else if (init_cnt != 0) init_cnt <= init_cnt - 1;
    end
    assign spi_busy = (init_cnt != 0) || xfer_busy;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        spi_err = 1'($urandom);
    endtask

    task automatic rand_cmds();
        r_block_i       = 2'($urandom);
        r_multi_block_i = 2'($urandom);
        r_byte_i        = 2'($urandom);
        block_addr0_i   = $urandom;
        block_addr1_i   = $urandom;
    endtask

    logic        e_rb, e_mb, e_by;
    logic [31:0] e_ad;
    grant_t      it;

    always @(negedge clk) begin
        if (mon_en) begin
            chk(gnt_o == exp_gnt, "gnt", 32'(gnt_o), 32'(exp_gnt));
            chk(timeout_o == exp_tmo, "timeout", 32'(timeout_o), 32'(exp_tmo));
            for (int i = 0; i < 2; i++) begin
                chk(busy_o[i] == (exp_gnt[i] ? spi_busy : 1'b1), "busy_o", 32'(busy_o), 32'(i));
                chk(err_o[i] == (exp_gnt[i] & spi_err), "err_o", 32'(err_o), 32'(i));
            end
            e_rb = 1'b0; e_mb = 1'b0; e_by = 1'b0; e_ad = 32'd0;
            for (int i = 0; i < 2; i++) begin
                if (exp_gnt[i] && req_i[i]) begin
                    e_rb = r_block_i[i];
                    e_mb = r_multi_block_i[i];
                    e_by = r_byte_i[i];
                    e_ad = (i == 1) ? block_addr1_i : block_addr0_i;
                end
            end
            chk(spi_r_block == e_rb, "spi_r_block", 32'(spi_r_block), 32'(e_rb));
            chk(spi_r_multi_block == e_mb, "spi_r_multi_block", 32'(spi_r_multi_block), 32'(e_mb));
            chk(spi_r_byte == e_by, "spi_r_byte", 32'(spi_r_byte), 32'(e_by));
            chk(spi_block_addr == e_ad, "spi_block_addr", spi_block_addr, e_ad);
            if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
                chk(exp_q.size() != 0, "grant_expected", 32'(gnt_o), 32'd0);
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    chk(gnt_o == (it.own ? 2'b10 : 2'b01), "grant_owner", 32'(gnt_o), it.own ? 32'd2 : 32'd1);
                    chk(cyc == it.at_cyc, "grant_cycle", 32'(cyc), 32'(it.at_cyc));
                end
            end
        end
        prev_gnt = gnt_o;
    end

    // One arbitration round starting with the arbiter idle.
    task automatic session(input logic [1:0] pat, input int hold, input int tail,
                           input bit tmo, input bit midrst);
        logic   own;
        bit     do_rst;
        int     e, g;
        grant_t ng;
        own    = (pat == 2'b11) ? ~last_m : pat[1];
        do_rst = force_m || (own != last_m);
        req_i  = pat;
        e      = cyc + 1;
        g      = e + 1 + (do_rst ? RSTC + INIT_BUSY : 0);
        ng.own = own;
        ng.at_cyc = g;
        exp_q.push_back(ng);
        if (do_rst) begin
            force_m = 1'b0;
            step();
            for (int i = 0; i < RSTC; i++) begin
                chk(spi_rst == 1'b1, "spi_rst_hold", 32'(spi_rst), 32'd1);
                step();
            end
            chk(spi_rst == 1'b0, "spi_rst_drop", 32'(spi_rst), 32'd0);
        end
        while (cyc < g) step();
        exp_gnt = own ? 2'b10 : 2'b01;
        for (int i = 0; i < hold; i++) begin
            rand_cmds();
            if (i == 0) begin
                r_block_i     = 2'b11;
                block_addr0_i = 32'h22;
                block_addr1_i = 32'h11;
            end
            req_i[~own] = 1'($urandom);
            step();
        end
        if (midrst) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            req_i = 2'b00;
            exp_gnt = 2'b00;
            exp_tmo = 1'b0;
            last_m = 1'b1;
            force_m = 1'b1;
            chk(spi_rst == 1'b1, "midrst_spi_rst", 32'(spi_rst), 32'd1);
        end else if (tmo) begin
            xfer_busy = 1'b1;
            for (int i = 0; i < TMO; i++) step();
            exp_gnt = 2'b00;
            exp_tmo = 1'b1;
            xfer_busy = 1'b0;
            req_i = 2'b00;
            force_m = 1'b1;
            last_m = own;
            step();
        end else begin
            req_i = pat & (own ? 2'b01 : 2'b10);
            xfer_busy = (tail > 0);
            for (int i = 0; i < tail; i++) begin
                rand_cmds();
                step();
            end
            xfer_busy = 1'b0;
            step();
            exp_gnt = 2'b00;
            last_m = own;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 2'b00; xfer_busy = 1'b0; spi_err = 1'b0;
        r_block_i = 2'b00; r_multi_block_i = 2'b00; r_byte_i = 2'b00;
        block_addr0_i = 32'd0; block_addr1_i = 32'd0;
        exp_gnt = 2'b00; exp_tmo = 1'b0; last_m = 1'b1; force_m = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        step(); step();
        chk(spi_rst == 1'b1, "reset_spi_rst", 32'(spi_rst), 32'd1);
        chk(gnt_o == 2'b00, "reset_gnt", 32'(gnt_o), 32'd0);
        rst = 1'b0;
        step(); step();
        chk(spi_rst == 1'b1, "idle_spi_rst", 32'(spi_rst), 32'd1);

        session(2'b11, 4, 0, 1'b0, 1'b0);
        session(2'b11, 3, 0, 1'b0, 1'b0);
        session(2'b10, 5, 40, 1'b0, 1'b0);
        for (int n = 0; n < 25; n++) begin
            if (req_i == 2'b00) repeat ($urandom_range(0, 3)) step();
            session(2'($urandom_range(1, 3)), $urandom_range(1, 6), $urandom_range(0, 5), 1'b0, 1'b0);
        end
        session(2'b01, 2, 0, 1'b1, 1'b0);
        session(2'b01, 2, 0, 1'b0, 1'b0);
        session(2'b11, 3, 0, 1'b0, 1'b1);
        session(2'b11, 2, 0, 1'b0, 1'b0);
        repeat (3) step();
        chk(exp_q.size() == 0, "grants_outstanding", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d want completion", cyc);
        $fatal(1);
    end

endmodule

// File: doc/sd_access_arbiter.md
SD_ACCESS_ARBITER -- requirements
Module: sd_access_arbiter

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of cycles spi_rst is held high on each owner handover.
REQ-002 Parameter TIMEOUT_CYCLES, default 2**24: continuous spi_busy cycles in GRANTED that trigger a forced release.
REQ-003 Parameter RESET_ON_SWITCH, default 1: 1 = reset the SD host whenever the new owner differs from the previous owner.
REQ-004 clk  in  1  system clock; one clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_i  in  2  access request; bit 0 = raw reader, bit 1 = eLUKS engine.
REQ-007 gnt_o  out  2  one-hot grant; 00 = no owner.
REQ-008 r_block_i, r_multi_block_i, r_byte_i  in  2 each  per-requester command strobes.
REQ-009 block_addr0_i, block_addr1_i  in  32 each  per-requester block address.
REQ-010 spi_r_block, spi_r_multi_block, spi_r_byte  out  1 each  commands to the SD host.
REQ-011 spi_block_addr  out  32  address to the SD host.
REQ-012 spi_rst  out  1  SD host reset.
REQ-013 spi_busy, spi_err  in  1 each  SD host status.
REQ-014 busy_o, err_o  out  2 each  per-requester status view.
REQ-015 timeout_o  out  1  sticky watchdog flag.

Function
REQ-016 The FSM SHALL have five states: IDLE, RST_HOST, WAIT_READY, GRANTED, RELEASE.
REQ-017 IDLE: if any req_i bit is high, the arbiter SHALL select an owner round-robin; on a tie the requester other than last_owner wins.
- From IDLE, go to RST_HOST if RESET_ON_SWITCH=1 and owner != last_owner; else go to WAIT_READY.
REQ-018 RST_HOST: spi_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_READY.
REQ-019 WAIT_READY: spi_rst=0; go to GRANTED on the first cycle with spi_busy=0 (SD host initialisation finished).
REQ-020 GRANTED: gnt_o[owner]=1, registered.
- spi_r_block, spi_r_multi_block, spi_r_byte and spi_block_addr SHALL be a combinational pass-through of the owner's inputs, gated by req_i[owner].
REQ-021 GRANTED exits to RELEASE when req_i[owner]=0 and spi_busy=0 in the same cycle.
- If req drops while spi_busy=1, the grant SHALL be held, with commands forced to 0, until busy clears.
REQ-022 Watchdog: a 32-bit counter increments on each GRANTED cycle with spi_busy=1 and clears when spi_busy=0.
- On reaching TIMEOUT_CYCLES: set timeout_o, go to RELEASE, and force the next grant through RST_HOST regardless of RESET_ON_SWITCH.
REQ-023 RELEASE: lasts 1 cycle; gnt_o=00, all commands 0; last_owner<=owner; then go to IDLE.
REQ-024 busy_o[i] SHALL be spi_busy when gnt_o[i]=1, else 1.
- err_o[i] SHALL be spi_err when gnt_o[i]=1, else 0.
REQ-025 Outside GRANTED: spi commands=0 and spi_block_addr=0; a non-owner's strobes SHALL never reach the SD host.
REQ-026 Latency with reset on switch: req rise to gnt_o high = 1 (IDLE) + RST_CYCLES + WAIT_READY cycles.
- Latency without reset: minimum 2 cycles.
REQ-027 A requester asserting req_i while the other is GRANTED SHALL wait; no preemption except by the watchdog.
REQ-028 timeout_o SHALL clear only on rst.

Reset
REQ-029 On rst=1 at a clock edge, from any state including mid-transfer:
- state=IDLE, gnt_o=00, spi commands=0, spi_block_addr=0.
- spi_rst=1, holding the SD host in reset until the next RST_HOST or WAIT_READY exit.
- last_owner=1, so requester 0 wins the first tie.
- watchdog=0, timeout_o=0.
REQ-030 The first grant after reset SHALL always pass through RST_HOST.

Verification
REQ-031 After rst, req_i=11 with RST_CYCLES=16 and spi_busy low after 5 WAIT_READY cycles -> gnt_o=01 exactly 1+16+5 cycles after req; spi_rst high for 16 cycles.
REQ-032 Owner 0 drops req, both request again -> RELEASE 1 cycle, then gnt_o=10 (round-robin); with RESET_ON_SWITCH=0, gnt_o=10 two cycles after IDLE.
REQ-033 Owner 1 drives r_block=1, addr=0x11 while requester 0 drives r_block=1, addr=0x22 -> spi_r_block=1, spi_block_addr=0x11 only; busy_o[0]=1 throughout.
REQ-034 Owner drops req while spi_busy=1 for 40 cycles -> gnt_o held 40 cycles with commands 0, released on the first busy-low cycle.
REQ-035 TIMEOUT_CYCLES=100, spi_busy stuck high -> timeout_o=1 and gnt_o=00 after 100 busy cycles; next grant passes through RST_HOST.
REQ-036 rst pulsed mid-GRANTED -> next cycle gnt_o=00, spi_rst=1, commands 0, timeout_o=0.
